// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        PUSH,
        BREAK
    } state_t;

    function automatic int cycles_per_bit(input int clk_mhz, input int baud);
        return (clk_mhz * 1000000) / baud;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead FIFO holding received bytes until the consumer pops them.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     full,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (level == '0);
    assign full    = (level == FULL_LEVEL);
    assign do_rd   = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_wr && !do_rd) begin
                level <= level + 1'b1;
            end else if (do_rd && !do_wr) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// UART receiver with majority voting, error pulses and an output FIFO.
// Define UART_RX_PARITY_EN to receive and check one parity bit per frame.
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_FRE    = 50,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx_pin,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_data_valid,
    input  logic                          rx_data_ready,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int          CYCLE     = cycles_per_bit(CLK_FRE, BAUD_RATE);
    localparam int          HALF      = CYCLE / 2;
    localparam logic [15:0] CNT_LAST  = 16'(CYCLE - 1);
    localparam logic [15:0] CNT_HALF  = 16'(HALF);
    localparam logic [15:0] CNT_V0    = 16'(HALF - 2);
    localparam logic [15:0] CNT_V1    = 16'(HALF - 1);
    localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic        LAST_STOP = (STOP_BITS == 2);

    state_t                 state;
    state_t                 next_state;
    logic                   sync_0;
    logic                   sync_1;
    logic                   rx_prev;
    logic [15:0]            cycle_cnt;
    logic [2:0]             bit_cnt;
    logic                   stop_cnt;
    logic [DATA_BITS-1:0]   shift;
    logic                   vote_a;
    logic                   vote_b;
    logic                   parity_bad;
    logic                   at_half;
    logic                   at_last;
    logic                   vote;
    logic                   fall_edge;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_wr;

    assign at_half   = (cycle_cnt == CNT_HALF);
    assign at_last   = (cycle_cnt == CNT_LAST);
    assign vote      = majority3(vote_a, vote_b, sync_1);
    assign fall_edge = rx_prev && !sync_1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        fifo_wr    = 1'b0;
        case (state)
            IDLE:   if (fall_edge) next_state = START;
            START: begin
                if (at_half && vote) begin
                    next_state = IDLE;
                end else if (at_last) begin
                    next_state = DATA;
                end
            end
            DATA: begin
                if (at_last && (bit_cnt == LAST_BIT)) begin
`ifdef UART_RX_PARITY_EN
                    next_state = PARITY;
`else
                    next_state = STOP;
`endif
                end
            end
            PARITY: if (at_last) next_state = STOP;
            // Leaving at mid stop bit gives half a bit of margin to catch the next start edge.
            STOP: begin
                if (at_half) begin
                    if (!vote) begin
                        next_state = BREAK;
                    end else if (stop_cnt == LAST_STOP) begin
                        next_state = PUSH;
                    end
                end
            end
            PUSH: begin
                fifo_wr    = !parity_bad && (!fifo_full || rx_data_ready);
                next_state = IDLE;
            end
            BREAK:  if (sync_1) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_0     <= 1'b1;
            sync_1     <= 1'b1;
            rx_prev    <= 1'b1;
            cycle_cnt  <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            shift      <= '0;
            vote_a     <= 1'b1;
            vote_b     <= 1'b1;
            parity_bad <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            sync_0  <= rx_pin;
            sync_1  <= sync_0;
            rx_prev <= sync_1;
            if ((state != next_state) || at_last) begin
                cycle_cnt <= '0;
            end else begin
                cycle_cnt <= cycle_cnt + 16'd1;
            end
            if (cycle_cnt == CNT_V0) vote_a <= sync_1;
            if (cycle_cnt == CNT_V1) vote_b <= sync_1;
            if (state == IDLE) begin
                bit_cnt    <= '0;
                stop_cnt   <= 1'b0;
                parity_bad <= 1'b0;
            end
            if (state == DATA) begin
                if (at_half) shift[bit_cnt] <= vote;
                if (at_last) bit_cnt <= bit_cnt + 3'd1;
            end
            if ((state == PARITY) && at_half) begin
                parity_bad <= ((^shift) ^ vote) != PARITY_ODD[0];
            end
            if ((state == STOP) && at_last) begin
                stop_cnt <= stop_cnt + 1'b1;
            end
            frame_err <= (state == STOP) && at_half && !vote;
`ifdef UART_RX_PARITY_EN
            parity_err <= (state == PUSH) && parity_bad;
`else
            parity_err <= 1'b0;
`endif
            overrun <= (state == PUSH) && !parity_bad && fifo_full && !rx_data_ready;
        end
    end

    assign rx_data_valid = !fifo_empty;

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (fifo_wr),
        .wr_data (shift),
        .full    (fifo_full),
        .rd_en   (rx_data_ready),
        .rd_data (rx_data),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench for uart_rx_buffered at 50 MHz / 115200 baud (434 clk per bit).
// Define UART_RX_PARITY_EN to add the parity frames.
module tb_uart_rx_buffered;

    localparam int CYCLE = 434;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_pin;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_data_ready;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic [2:0] fifo_level;

    int tests_run    = 0;
    int tests_failed = 0;
    int valid_cycles = 0;
    int fe_cnt       = 0;
    int pe_cnt       = 0;
    int ov_cnt       = 0;
    int exp_pops     = 0;
    logic [7:0] popped [$];

    always #5 clk = ~clk;

    uart_rx_buffered #(
        .CLK_FRE    (50),
        .BAUD_RATE  (115200),
        .DATA_BITS  (8),
        .STOP_BITS  (1),
        .FIFO_DEPTH (4),
        .PARITY_ODD (0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_pin        (rx_pin),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rx_data_ready (rx_data_ready),
        .frame_err     (frame_err),
        .parity_err    (parity_err),
        .overrun       (overrun),
        .fifo_level    (fifo_level)
    );

    // Record every accepted byte and every error pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_data_valid && rx_data_ready) popped.push_back(rx_data);
            if (rx_data_valid) valid_cycles++;
            if (frame_err) fe_cnt++;
            if (parity_err) pe_cnt++;
            if (overrun) ov_cnt++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] poppedAt(input int idx);
        if (idx < popped.size()) return {24'h0, popped[idx]};
        return 32'hDEAD_BEEF;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sendBit(input logic b, input int glitch_at);
        rx_pin = b;
        for (int i = 0; i < CYCLE; i++) begin
            if (i == glitch_at) rx_pin = ~b;
            else if (i == glitch_at + 1) rx_pin = b;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sendHead(input logic [7:0] d, input int glitch_bit);
        sendBit(1'b0, -1);
        for (int k = 0; k < 8; k++) begin
            sendBit(d[k], (k == glitch_bit) ? CYCLE / 2 : -1);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic stop_val, input int glitch_bit);
        sendHead(d, glitch_bit);
`ifdef UART_RX_PARITY_EN
        sendBit(^d, -1);
`endif
        sendBit(stop_val, -1);
    endtask

    initial begin
        rst_n         = 1'b0;
        rx_pin        = 1'b1;
        rx_data_ready = 1'b0;
        idle(5);
        checkOutput("reset_data", {24'h0, rx_data}, 32'h0);
        checkOutput("reset_valid", {31'h0, rx_data_valid}, 32'h0);
        checkOutput("reset_level", {29'h0, fifo_level}, 32'h0);
        checkOutput("reset_flags", {29'h0, frame_err, parity_err, overrun}, 32'h0);
        rst_n = 1'b1;
        idle(20);

        // Single frame, consumer always ready.
        rx_data_ready = 1'b1;
        applyStimulus(8'hA5, 1'b1, -1);
        idle(20);
        exp_pops = 1;
        checkOutput("t1_count", popped.size(), exp_pops);
        checkOutput("t1_byte", poppedAt(0), 32'hA5);
        checkOutput("t1_valid_cycles", valid_cycles, 1);
        checkOutput("t1_errors", fe_cnt + pe_cnt + ov_cnt, 0);
        checkOutput("t1_level", {29'h0, fifo_level}, 32'h0);

        // Short low glitch must be rejected as a false start.
        rx_pin = 1'b0;
        idle(100);
        rx_pin = 1'b1;
        idle(1000);
        checkOutput("t2_count", popped.size(), exp_pops);
        checkOutput("t2_errors", fe_cnt + pe_cnt + ov_cnt, 0);
        checkOutput("t2_valid", {31'h0, rx_data_valid}, 32'h0);

        // Low stop bit followed by a held-low line, then a clean frame.
        applyStimulus(8'h3C, 1'b0, -1);
        idle(2000);
        rx_pin = 1'b1;
        idle(50);
        checkOutput("t3_frame_err", fe_cnt, 1);
        checkOutput("t3_count", popped.size(), exp_pops);
        checkOutput("t3_level", {29'h0, fifo_level}, 32'h0);
        applyStimulus(8'h55, 1'b1, -1);
        idle(20);
        exp_pops++;
        checkOutput("t3_next_count", popped.size(), exp_pops);
        checkOutput("t3_next_byte", poppedAt(1), 32'h55);
        checkOutput("t3_fe_once", fe_cnt, 1);

        // Fill the FIFO with the consumer stalled, then overrun it.
        rx_data_ready = 1'b0;
        for (int f = 1; f <= 4; f++) applyStimulus(8'(f), 1'b1, -1);
        checkOutput("t4_level_full", {29'h0, fifo_level}, 32'h4);
        checkOutput("t4_no_overrun", ov_cnt, 0);
        applyStimulus(8'h05, 1'b1, -1);
        idle(20);
        checkOutput("t4_overrun", ov_cnt, 1);
        checkOutput("t4_level_held", {29'h0, fifo_level}, 32'h4);
        checkOutput("t4_head", {24'h0, rx_data}, 32'h01);
        rx_data_ready = 1'b1;
        idle(10);
        exp_pops += 4;
        checkOutput("t4_count", popped.size(), exp_pops);
        for (int f = 0; f < 4; f++) checkOutput("t4_byte", poppedAt(2 + f), 32'(f + 1));
        checkOutput("t4_level_empty", {29'h0, fifo_level}, 32'h0);

        // One-clock inversion at the centre of data bit 3.
        applyStimulus(8'h00, 1'b1, 3);
        idle(20);
        exp_pops++;
        checkOutput("t5_count", popped.size(), exp_pops);
        checkOutput("t5_byte", poppedAt(exp_pops - 1), 32'h00);
        checkOutput("t5_errors", fe_cnt + pe_cnt + ov_cnt, 2);

`ifdef UART_RX_PARITY_EN
        // 0x07 has odd weight, so even parity needs a 1 in the parity slot.
        sendHead(8'h07, -1);
        sendBit(1'b0, -1);
        sendBit(1'b1, -1);
        idle(20);
        checkOutput("t6_parity_err", pe_cnt, 1);
        checkOutput("t6_dropped", popped.size(), exp_pops);
        sendHead(8'h07, -1);
        sendBit(1'b1, -1);
        sendBit(1'b1, -1);
        idle(20);
        exp_pops++;
        checkOutput("t6_good_count", popped.size(), exp_pops);
        checkOutput("t6_good_byte", poppedAt(exp_pops - 1), 32'h07);
        checkOutput("t6_pe_once", pe_cnt, 1);
`endif

        // Reset during bit 4 of 0xF2 (bits 4..7 high) with one byte already buffered.
        rx_data_ready = 1'b0;
        applyStimulus(8'h5A, 1'b1, -1);
        idle(10);
        checkOutput("t7_buffered", {29'h0, fifo_level}, 32'h1);
        sendBit(1'b0, -1);
        for (int k = 0; k < 4; k++) sendBit(k == 1, -1);
        rx_pin = 1'b1;
        idle(100);
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(20);
        checkOutput("t7_level", {29'h0, fifo_level}, 32'h0);
        checkOutput("t7_valid", {31'h0, rx_data_valid}, 32'h0);
        checkOutput("t7_data", {24'h0, rx_data}, 32'h0);
        idle(CYCLE * 5);
        checkOutput("t7_no_delivery", popped.size(), exp_pops);
        checkOutput("t7_level_late", {29'h0, fifo_level}, 32'h0);
        rx_data_ready = 1'b1;
        applyStimulus(8'h96, 1'b1, -1);
        idle(20);
        exp_pops++;
        checkOutput("t7_after_count", popped.size(), exp_pops);
        checkOutput("t7_after_byte", poppedAt(exp_pops - 1), 32'h96);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
